axi_sram_burst_slave: RTL and testbench
=======================================

Name: axi_sram_burst_slave

Overview:
Parametrised AXI3-style SRAM slave, the successor to the fixed 32-bit platform system SRAM. Generalised in data width, depth, ID width and base address. Adds full FIXED/INCR/WRAP burst addressing, narrow transfers, and per-beat SLVERR on out-of-range accesses. Sits behind the platform interconnect as a memory-mapped slave. Its rx* AXI ports connect directly to the interconnect's slave-side sx* signals.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 32, 64 or 128.
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 4, transaction ID width; equals the platform's slave TID width.
DEPTH, 4096, number of DATA_WIDTH-bit words; power of two.
BASE_ADDR, 0, byte address of word 0.

Ports:
clk  in  1  single clock for all logic.
rstnn  in  1  asynchronous active-low reset.
rxawvalid/rxawready  in/out  1  AW handshake.
rxawaddr  in  ADDR_WIDTH  write start byte address.
rxawid  in  ID_WIDTH  write ID.
rxawlen  in  8  beats-1.
rxawsize  in  3  log2 bytes per beat.
rxawburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
rxwvalid/rxwready  in/out  1  W handshake.
rxwid  in  ID_WIDTH  ignored.
rxwdata  in  DATA_WIDTH  write data.
rxwstrb  in  DATA_WIDTH/8  byte enables.
rxwlast  in  1  last write beat.
rxbvalid/rxbready  out/in  1  B handshake.
rxbid  out  ID_WIDTH  latched AWID.
rxbresp  out  2  write response.
rxarvalid/rxarready  in/out  1  AR handshake.
rxaraddr, rxarid, rxarlen, rxarsize, rxarburst  in  ADDR_WIDTH/ID_WIDTH/8/3/2  read request fields.
rxrvalid/rxrready  out/in  1  R handshake.
rxrid  out  ID_WIDTH  latched ARID.
rxrdata  out  DATA_WIDTH  read data.
rxrlast  out  1  last read beat.
rxrresp  out  2  per-beat read response.

Behaviour:
- Reset: all outputs 0. Both FSMs enter IDLE. rxawready/rxarready stay 0 until the first clk edge after rstnn deasserts, then go 1. Memory contents are not reset.
- Reset mid-burst: the burst is abandoned and no response is issued. Partially written beats remain in memory.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake latch addr/id/len/size/burst, clear the error flag, go to W_DATA.
  - W_DATA (wready=1): each W handshake writes the bytes where wstrb=1 at the current word, then advances the address.
  - After len+1 beats, go to W_RESP. Beat count governs termination; rxwlast does not.
  - W_RESP (bvalid=1, bresp=10 if the error flag is set, else 00): hold until bready, then go to W_IDLE.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch fields and go to R_READ.
  - R_READ: issue a synchronous memory read, go to R_DATA.
  - R_DATA: rvalid=1; rdata/rresp/rlast are stable until rready. On handshake, go to R_IDLE if last, else advance the address and go to R_READ.
  - Throughput is one beat per 2 cycles. AR-handshake-to-first-rvalid latency is 2 cycles.
- Read and write FSMs are independent and may run concurrently. A same-cycle read and write to the same word returns old data.
- Address generation: beat step = 2^size bytes.
  - FIXED: the address never changes.
  - INCR: addr += step.
  - WRAP: boundary = (len+1)*step aligned down; the address wraps to the boundary on reaching boundary+(len+1)*step.
  - WRAP with len not in {1,3,7,15}, and burst=11, are treated as INCR.
  - size > log2(DATA_WIDTH/8) clamps to the full width.
  - Word index = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
- Range check (per beat): addr < BASE_ADDR or index ≥ DEPTH is an error.
  - Write: strobes are suppressed and the error flag is set.
  - Read: rdata=0 and rresp=10 for that beat only.
- Any W beat with rxwlast disagreeing with the beat count sets the error flag. The beat is still written.
- Narrow transfers use wstrb lanes as given. Reads always return the full word.

Test Plan:
- Single write: AW addr=BASE+0x10, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF → bresp=00 and bid=awid. Then AR to the same address → rdata=0xDEADBEEF, rlast=1, rresp=00, and rvalid arrives 2 cycles after the AR handshake.
- INCR write len=3 of 1,2,3,4 at BASE+0x0, then WRAP read len=3 at BASE+0x8 → rdata sequence 3,4,1,2 with rlast on the 4th beat.
- Byte strobe: word preloaded with 0x11223344, write 0xAABBCCDD with wstrb=0x5 → read returns 0x11BB33DD.
- Out of range: INCR read len=1 starting at the last word → beat0 rresp=00, beat1 rresp=10 with rdata=0. The equivalent write → bresp=10 and the last word is unchanged beyond beat0.
- Backpressure and concurrency: hold rready=0 for 5 cycles mid-burst → rdata is stable. A write burst during the read completes with correct bresp, and a same-word collision returns old data.
- Early wlast on beat 1 of len=3 → all 4 beats are written and bresp=10. A reset asserted mid-burst → all outputs are 0 and ready returns 1 cycle after release.

Source files
------------

// File: rtl/axi_sram_burst_slave.sv
// AXI3-style SRAM slave: independent write/read FSMs, FIXED/INCR/WRAP bursts,
// narrow writes via byte strobes, per-beat SLVERR on out-of-range addresses.
// Storage is split into one byte-wide bank per lane so strobes map to bank enables.

// One byte lane of storage: one write port and one synchronous read port.
module axi_sram_lane #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  // Read-before-write: a same-edge read of the written word sees the old byte.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module axi_sram_burst_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    rxawvalid,
  output logic                    rxawready,
  input  logic [ADDR_WIDTH-1:0]   rxawaddr,
  input  logic [ID_WIDTH-1:0]     rxawid,
  input  logic [7:0]              rxawlen,
  input  logic [2:0]              rxawsize,
  input  logic [1:0]              rxawburst,
  input  logic                    rxwvalid,
  output logic                    rxwready,
  input  logic [ID_WIDTH-1:0]     rxwid,
  input  logic [DATA_WIDTH-1:0]   rxwdata,
  input  logic [DATA_WIDTH/8-1:0] rxwstrb,
  input  logic                    rxwlast,
  output logic                    rxbvalid,
  input  logic                    rxbready,
  output logic [ID_WIDTH-1:0]     rxbid,
  output logic [1:0]              rxbresp,
  input  logic                    rxarvalid,
  output logic                    rxarready,
  input  logic [ADDR_WIDTH-1:0]   rxaraddr,
  input  logic [ID_WIDTH-1:0]     rxarid,
  input  logic [7:0]              rxarlen,
  input  logic [2:0]              rxarsize,
  input  logic [1:0]              rxarburst,
  output logic                    rxrvalid,
  input  logic                    rxrready,
  output logic [ID_WIDTH-1:0]     rxrid,
  output logic [DATA_WIDTH-1:0]   rxrdata,
  output logic                    rxrlast,
  output logic [1:0]              rxrresp
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } req_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} rstate_e;

  // Next beat address; oversize beats clamp to the bus width, and WRAP with an
  // illegal length (or the reserved burst code) falls back to INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input req_t r);
    logic [2:0]            sz;
    logic [ADDR_WIDTH-1:0] step, mask;
    logic                  wrap;
    sz   = (r.size > 3'(LANE_BITS)) ? 3'(LANE_BITS) : r.size;
    step = ADDR_WIDTH'(1) << sz;
    mask = ((ADDR_WIDTH'(r.len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    wrap = (r.burst == 2'b10) &&
           (r.len == 8'd1 || r.len == 8'd3 || r.len == 8'd7 || r.len == 8'd15);
    if (r.burst == 2'b00) return r.addr;
    if (wrap)             return (r.addr & ~mask) | ((r.addr + step) & mask);
    return r.addr + step;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || ((off >> LANE_BITS) >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> LANE_BITS;
    return off[IDX_W-1:0];
  endfunction

  logic    rdy_en;
  wstate_e w_state, w_nxt;
  rstate_e r_state, r_nxt;
  req_t    wreq, rreq;
  logic [7:0] w_cnt, r_cnt;
  logic    w_err, r_err;
  logic    aw_hs, w_hs, ar_hs, w_last_beat, r_last_beat, w_oor, rd_en;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic    unused_wid;

  assign unused_wid  = ^rxwid;
  assign aw_hs       = rxawvalid & rxawready;
  assign w_hs        = rxwvalid & rxwready;
  assign ar_hs       = rxarvalid & rxarready;
  assign w_last_beat = (w_cnt == wreq.len);
  assign r_last_beat = (r_cnt == rreq.len);
  assign w_oor       = out_of_range(wreq.addr);
  assign w_idx       = word_idx(wreq.addr);
  assign r_idx       = word_idx(rreq.addr);
  assign rd_en       = (r_state == R_READ);

  // Holds the address channels closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // ---------------- write channel ----------------
  // Write state register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) w_state <= W_IDLE;
    else        w_state <= w_nxt;
  end

  // Write next state: termination follows the beat count, not rxwlast.
  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)                    w_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat)      w_nxt = W_RESP;
      W_RESP:  if (rxbready)                 w_nxt = W_IDLE;
      default:                               w_nxt = W_IDLE;
    endcase
  end

  // Write channel outputs.
  always_comb begin
    rxawready = rdy_en && (w_state == W_IDLE);
    rxwready  = (w_state == W_DATA);
    rxbvalid  = (w_state == W_RESP);
    rxbresp   = (rxbvalid && w_err) ? 2'b10 : 2'b00;
    rxbid     = wreq.id;
  end

  // Write request latch, beat counter and sticky error (range or wlast mismatch).
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wreq  <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      wreq  <= '{addr: rxawaddr, id: rxawid, len: rxawlen, size: rxawsize, burst: rxawburst};
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_hs) begin
      wreq.addr <= next_addr(wreq);
      w_cnt     <= w_cnt + 8'd1;
      w_err     <= w_err | w_oor | (rxwlast ^ w_last_beat);
    end
  end

  // ---------------- read channel ----------------
  // Read state register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) r_state <= R_IDLE;
    else        r_state <= r_nxt;
  end

  // Read next state: one memory cycle then one presentation cycle per beat.
  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)    r_nxt = R_READ;
      R_READ:                r_nxt = R_DATA;
      R_DATA:  if (rxrready) r_nxt = r_last_beat ? R_IDLE : R_READ;
      default:               r_nxt = R_IDLE;
    endcase
  end

  // Read channel outputs; an out-of-range beat presents zero data.
  always_comb begin
    rxarready = rdy_en && (r_state == R_IDLE);
    rxrvalid  = (r_state == R_DATA);
    rxrlast   = rxrvalid && r_last_beat;
    rxrresp   = (rxrvalid && r_err) ? 2'b10 : 2'b00;
    rxrdata   = (rxrvalid && !r_err) ? rd_word : '0;
    rxrid     = rreq.id;
  end

  // Read request latch, beat counter and per-beat range flag.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rreq  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (ar_hs) begin
      rreq  <= '{addr: rxaraddr, id: rxarid, len: rxarlen, size: rxarsize, burst: rxarburst};
      r_cnt <= '0;
    end else if (r_state == R_READ) begin
      r_err <= out_of_range(rreq.addr);
    end else if (rxrvalid && rxrready && !r_last_beat) begin
      rreq.addr <= next_addr(rreq);
      r_cnt     <= r_cnt + 8'd1;
    end
  end

  // Byte-lane banks; an out-of-range beat suppresses every strobe.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axi_sram_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (w_hs & rxwstrb[g] & ~w_oor),
      .waddr (w_idx),
      .wdata (rxwdata[g*8 +: 8]),
      .re    (rd_en),
      .raddr (r_idx),
      .rdata (rd_word[g])
    );
  end
endmodule

// File: tb/tb_axi_sram_burst_slave.sv
// Randomized bench for axi_sram_burst_slave against a word-array reference model.
module tb_axi_sram_burst_slave;
  localparam int          DW   = 32;
  localparam int          DEP  = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk, rstnn;
  logic rxawvalid, rxawready; logic [31:0] rxawaddr; logic [3:0] rxawid;
  logic [7:0] rxawlen; logic [2:0] rxawsize; logic [1:0] rxawburst;
  logic rxwvalid, rxwready; logic [3:0] rxwid; logic [31:0] rxwdata; logic [3:0] rxwstrb; logic rxwlast;
  logic rxbvalid, rxbready; logic [3:0] rxbid; logic [1:0] rxbresp;
  logic rxarvalid, rxarready; logic [31:0] rxaraddr; logic [3:0] rxarid;
  logic [7:0] rxarlen; logic [2:0] rxarsize; logic [1:0] rxarburst;
  logic rxrvalid, rxrready; logic [3:0] rxrid; logic [31:0] rxrdata; logic rxrlast; logic [1:0] rxrresp;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [DEP];
  logic [31:0] dq[$];
  logic [3:0]  sq[$];

  axi_sram_burst_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstnn(rstnn),
    .rxawvalid(rxawvalid), .rxawready(rxawready), .rxawaddr(rxawaddr), .rxawid(rxawid),
    .rxawlen(rxawlen), .rxawsize(rxawsize), .rxawburst(rxawburst),
    .rxwvalid(rxwvalid), .rxwready(rxwready), .rxwid(rxwid), .rxwdata(rxwdata),
    .rxwstrb(rxwstrb), .rxwlast(rxwlast),
    .rxbvalid(rxbvalid), .rxbready(rxbready), .rxbid(rxbid), .rxbresp(rxbresp),
    .rxarvalid(rxarvalid), .rxarready(rxarready), .rxaraddr(rxaraddr), .rxarid(rxarid),
    .rxarlen(rxarlen), .rxarsize(rxarsize), .rxarburst(rxarburst),
    .rxrvalid(rxrvalid), .rxrready(rxrready), .rxrid(rxrid), .rxrdata(rxrdata),
    .rxrlast(rxrlast), .rxrresp(rxrresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address of beat i from the burst rules, computed by plain arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    int unsigned es, step, total, lower, a;
    es    = (size > 3'd2) ? 2 : int'(size);
    step  = 1 << es;
    total = (int'(len) + 1) * step;
    if (burst == 2'b00) return start;
    a = start + i * step;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      lower = start - (start % total);
      while (a >= lower + total) a = a - total;
    end
    return a;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEP);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Write burst; early = beat flagged with a premature wlast, abort = stop before that beat.
  task automatic axi_wr(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input logic [31:0] d[$], input logic [3:0] s[$], input int early, input int abort);
    int t; logic err; logic [31:0] a;
    err = 1'b0;
    rxawaddr = addr; rxawid = id; rxawlen = len; rxawsize = size; rxawburst = burst; rxawvalid = 1'b1;
    t = 0; @(negedge clk);
    while (!rxawready && t < 200) begin @(negedge clk); t++; end
    chk("aw_ready", rxawready, 1);
    @(posedge clk); #1 rxawvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort) return;
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      rxwvalid = 1'b1; rxwdata = d[i]; rxwstrb = s[i]; rxwid = id;
      rxwlast = (i == int'(len)) || (i == early);
      t = 0; @(negedge clk);
      while (!rxwready && t < 200) begin @(negedge clk); t++; end
      chk("w_ready", rxwready, 1);
      @(posedge clk); #1 rxwvalid = 1'b0; rxwlast = 1'b0;
      a = beat_addr(addr, len, size, burst, i);
      if (!in_rng(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (s[i][b]) mdl[widx(a)][b*8 +: 8] = d[i][b*8 +: 8];
      if (i == early && i != int'(len)) err = 1'b1;
    end
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    rxbready = 1'b1;
    t = 0; @(negedge clk);
    while (!rxbvalid && t < 200) begin @(negedge clk); t++; end
    chk("b_valid", rxbvalid, 1);
    chk("b_resp", rxbresp, err ? 2'b10 : 2'b00);
    chk("b_id", rxbid, id);
    @(posedge clk); #1 rxbready = 1'b0;
  endtask

  // Read burst checked beat by beat against the model.
  task automatic axi_rd(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input int stall_beat, input int stall_n, input bit lat);
    int t; logic [31:0] a, ed; logic [1:0] er;
    rxaraddr = addr; rxarid = id; rxarlen = len; rxarsize = size; rxarburst = burst; rxarvalid = 1'b1;
    t = 0; @(negedge clk);
    while (!rxarready && t < 200) begin @(negedge clk); t++; end
    chk("ar_ready", rxarready, 1);
    @(posedge clk); #1 rxarvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      t = 1;
      while (!rxrvalid && t < 50) begin @(posedge clk); #1; t++; end
      if (lat && i == 0) chk("ar_to_rvalid", t, 2);
      a  = beat_addr(addr, len, size, burst, i);
      ed = in_rng(a) ? mdl[widx(a)] : 32'h0;
      er = in_rng(a) ? 2'b00 : 2'b10;
      if (i == stall_beat)
        repeat (stall_n) begin chk("r_hold", {rxrvalid, rxrdata}, {1'b1, ed}); @(posedge clk); #1; end
      else if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      chk("r_valid", rxrvalid, 1);
      chk("r_data", rxrdata, ed);
      chk("r_resp", rxrresp, er);
      chk("r_last", rxrlast, i == int'(len));
      chk("r_id", rxrid, id);
      rxrready = 1'b1; @(posedge clk); #1 rxrready = 1'b0;
    end
  endtask

  logic [31:0] ta, old_w, new_w;
  logic [7:0]  ln;
  logic [2:0]  sz;
  logic [1:0]  bu;
  int unsigned es, off;

  initial begin
    rstnn = 1'b0;
    rxawvalid = 0; rxawaddr = 0; rxawid = 0; rxawlen = 0; rxawsize = 0; rxawburst = 0;
    rxwvalid = 0; rxwid = 0; rxwdata = 0; rxwstrb = 0; rxwlast = 0; rxbready = 0;
    rxarvalid = 0; rxaraddr = 0; rxarid = 0; rxarlen = 0; rxarsize = 0; rxarburst = 0; rxrready = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", {rxawready, rxwready, rxbvalid, rxbid, rxbresp, rxarready, rxrvalid,
                          rxrid, rxrdata, rxrlast, rxrresp}, 64'h0);
    @(negedge clk) rstnn = 1'b1;
    #1 chk("ready_held_after_release", {rxawready, rxarready}, 2'b00);
    @(posedge clk); #1 chk("ready_after_edge", {rxawready, rxarready}, 2'b11);

    // Fill memory so every word has a known value.
    dq = {}; sq = {};
    for (int i = 0; i < DEP; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_wr(BASE, 4'd0, 8'(DEP - 1), 3'd2, 2'b01, dq, sq, -1, -1);

    // Single beat write / read with latency check.
    dq = {32'hDEADBEEF}; sq = {4'hF};
    axi_wr(BASE + 32'h10, 4'd5, 8'd0, 3'd2, 2'b01, dq, sq, -1, -1);
    axi_rd(BASE + 32'h10, 4'd9, 8'd0, 3'd2, 2'b01, -1, 0, 1'b1);
    chk("single_word", mdl[4], 32'hDEADBEEF);

    // INCR write then WRAP read starting mid-block.
    dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    axi_wr(BASE, 4'd3, 8'd3, 3'd2, 2'b01, dq, sq, -1, -1);
    axi_rd(BASE + 32'h8, 4'd4, 8'd3, 3'd2, 2'b10, -1, 0, 1'b0);

    // Byte strobes.
    dq = {32'h11223344}; sq = {4'hF};
    axi_wr(BASE + 32'h20, 4'd1, 8'd0, 3'd2, 2'b01, dq, sq, -1, -1);
    dq = {32'hAABBCCDD}; sq = {4'h5};
    axi_wr(BASE + 32'h20, 4'd1, 8'd0, 3'd2, 2'b01, dq, sq, -1, -1);
    chk("strobe_merge", mdl[8], 32'h11BB33DD);
    axi_rd(BASE + 32'h20, 4'd2, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);

    // Out of range at the top and below the base.
    axi_rd(BASE + (DEP - 1) * 4, 4'd6, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);
    dq = {32'hCAFEF00D, 32'h0BADBEEF}; sq = {4'hF, 4'hF};
    axi_wr(BASE + (DEP - 1) * 4, 4'd7, 8'd1, 3'd2, 2'b01, dq, sq, -1, -1);
    axi_rd(BASE + (DEP - 1) * 4, 4'd6, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
    axi_rd(BASE - 32'h4, 4'd6, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);

    // Concurrent write burst and stalled read burst on disjoint regions.
    dq = {}; sq = {};
    for (int i = 0; i < 8; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    fork
      axi_wr(BASE + 32'h40, 4'd8, 8'd7, 3'd2, 2'b01, dq, sq, -1, -1);
      axi_rd(BASE + 32'h80, 4'd9, 8'd7, 3'd2, 2'b01, 3, 5, 1'b0);
    join

    // Same-word collision: read samples memory on the write beat's edge.
    ta = BASE + 32'hC0; old_w = mdl[widx(ta)]; new_w = ~old_w;
    @(posedge clk); #1;
    rxaraddr = ta; rxarid = 4'd2; rxarlen = 0; rxarsize = 3'd2; rxarburst = 2'b01; rxarvalid = 1'b1;
    rxawaddr = ta; rxawid = 4'd3; rxawlen = 0; rxawsize = 3'd2; rxawburst = 2'b01; rxawvalid = 1'b1;
    rxwdata = new_w; rxwstrb = 4'hF; rxwlast = 1'b1; rxwvalid = 1'b1;
    @(negedge clk) chk("coll_ready", {rxawready, rxarready}, 2'b11);
    @(posedge clk); #1 rxarvalid = 1'b0; rxawvalid = 1'b0;
    @(negedge clk) chk("coll_wready", rxwready, 1);
    @(posedge clk); #1 rxwvalid = 1'b0; rxwlast = 1'b0;
    chk("coll_rvalid", rxrvalid, 1);
    chk("coll_old_data", rxrdata, old_w);
    chk("coll_bresp", {rxbvalid, rxbresp}, 3'b100);
    rxrready = 1'b1; rxbready = 1'b1;
    @(posedge clk); #1 rxrready = 1'b0; rxbready = 1'b0;
    mdl[widx(ta)] = new_w;
    axi_rd(ta, 4'd2, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);

    // Premature wlast on beat 1: all beats land, response is SLVERR.
    dq = {}; sq = {};
    for (int i = 0; i < 4; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_wr(BASE + 32'h30, 4'd4, 8'd3, 3'd2, 2'b01, dq, sq, 1, -1);
    axi_rd(BASE + 32'h30, 4'd4, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);

    // Randomized bursts of every type, size and length.
    for (int n = 0; n < 30; n++) begin
      sz = 3'($urandom_range(0, 3));
      es = (sz > 3'd2) ? 2 : int'(sz);
      bu = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       ln = 8'($urandom_range(0, 15));
        1:       ln = 8'((2 << $urandom_range(0, 3)) - 1);
        default: ln = 8'($urandom_range(0, 3));
      endcase
      off = $urandom_range(0, DEP * 4 - 1);
      off = off & ~((32'd1 << es) - 1);
      dq = {}; sq = {};
      for (int i = 0; i <= int'(ln); i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
      axi_wr(BASE + off, 4'($urandom), ln, sz, bu, dq, sq, -1, -1);
      axi_rd(BASE + off, 4'($urandom), ln, sz, bu, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
    end

    // Reset in the middle of a write burst.
    dq = {}; sq = {};
    for (int i = 0; i < 8; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_wr(BASE + 32'hD0, 4'd5, 8'd7, 3'd2, 2'b01, dq, sq, -1, 3);
    rstnn = 1'b0;
    #1 chk("midburst_reset_outs", {rxawready, rxwready, rxbvalid, rxbid, rxbresp, rxarready, rxrvalid,
                                   rxrid, rxrdata, rxrlast, rxrresp}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstnn = 1'b1;
    #1 chk("midburst_ready_held", {rxawready, rxarready}, 2'b00);
    @(posedge clk); #1 chk("midburst_ready_back", {rxawready, rxarready}, 2'b11);
    axi_rd(BASE + 32'hD0, 4'd1, 8'd7, 3'd2, 2'b01, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
